fb_read_arbiter: RTL and testbench
==================================

// Module: fb_read_arbiter
// PURPOSE
//  Shares the single frame-buffer read port (port B, clk_vga domain) between two requesters:
//  the display pipeline (address generator -> RGB/filtering) and an auxiliary reader
//  (snapshot/statistics engine). Display has absolute priority and is never stalled.
//  Aux gets idle and blanking cycles through a req/gnt handshake.
//  Returned data is steered back to its owner by a latency-matched tag pipe.
// PARAMETERS
//  ADDR_W     17  frame-buffer word address width
//  DATA_W     12  pixel width (RGB444)
//  RD_LAT     1   BRAM read latency in cycles, legal 1..3
//  STARVE_MAX 8   aux wait cycles before aux_starved is raised, legal 1..255
// PORTS
//  pclk         in   1       clk_vga; single clock domain
//  rst          in   1       synchronous, active-high reset
//  disp_req     in   1       display read request this cycle (tied to activeArea)
//  disp_addr    in   ADDR_W  display read address
//  disp_data    out  DATA_W  display read data
//  disp_valid   out  1       disp_data valid pulse
//  aux_req      in   1       aux request; held with aux_addr stable until aux_gnt
//  aux_addr     in   ADDR_W  aux read address
//  aux_gnt      out  1       aux address accepted this cycle (combinational)
//  aux_data     out  DATA_W  aux read data
//  aux_valid    out  1       aux_data valid pulse
//  aux_starved  out  1       aux waited >= STARVE_MAX cycles; sticky until next aux_gnt
//  fb_addr      out  ADDR_W  registered address to frame-buffer port B
//  fb_dout      in   DATA_W  frame-buffer port B read data
// BEHAVIOUR
//  - Reset: fb_addr=0, disp_data=0, aux_data=0, disp_valid=0, aux_valid=0,
//    aux_starved=0, FSM=IDLE, wait_cnt=0, tag pipe cleared.
//  - Accept cycle t: if disp_req, disp_addr is taken; else if aux_req and grant allowed,
//    aux_addr is taken and aux_gnt=1.
//    fb_addr is registered at t+1; fb_dout is valid at t+1+RD_LAT.
//    Owner data/valid are registered at t+2+RD_LAT (L=3 for RD_LAT=1).
//  - Tag pipe: depth RD_LAT+1; entries are {NONE,DISP,AUX}. Exactly one valid pulses per accept.
//    When no request is accepted, fb_addr holds its value and tag=NONE.
//  - Both requesters active in the same cycle: display wins, aux_gnt=0.
//  - One grant per cycle max. Back-to-back aux grants are allowed while disp_req=0.
//  - Data outputs hold their last value when the corresponding valid=0.
//  - FSM (aux side):
//      IDLE: aux_req & !disp_req -> aux_gnt, stay IDLE.
//            aux_req & disp_req  -> WAIT, wait_cnt=1.
//      WAIT: !disp_req & aux_req -> aux_gnt, clear aux_starved, wait_cnt=0, -> IDLE.
//            disp_req -> wait_cnt++ (saturates at 255); wait_cnt==STARVE_MAX sets aux_starved.
//            !aux_req (protocol violation: request withdrawn) -> IDLE, no grant,
//            aux_starved unchanged.
//  - rst asserted mid-read: in-flight tags are discarded and no valid pulses are produced
//    after the reset cycle.
// CONFIGURATION
//  FB_ARB_STATS_EN defined: adds ports
//    stat_clr        in  1   clears both counters
//    stat_aux_grants out 16  saturating count of aux grants
//    stat_max_wait   out 8   maximum wait_cnt seen at grant
//    Counters are cleared by rst or stat_clr; stat_clr wins over a same-cycle increment.
//  FB_ARB_STATS_EN undefined: these ports and their logic are absent; all other
//    behaviour is identical.
// STRUCTURE
//  - fb_arb_pkg: ADDR_W/DATA_W defaults, owner tag encoding (NONE=0, DISP=1, AUX=2),
//    FSM state encoding (IDLE, WAIT).
//  - Sub-module fb_arb_tag_pipe: parameterised RD_LAT+1 shift register of owner tags
//    with synchronous clear.
//  - Top level holds the priority mux, the FSM and the output registers.
// TESTING
//  1. disp_req=1 with disp_addr=0..319 consecutively, RD_LAT=1 -> disp_valid continuous
//     from cycle 3; disp_data[n] = mem[n]; aux_gnt=0 throughout.
//  2. aux_req=1 with aux_addr=0x1ABCD, disp_req=0 -> aux_gnt same cycle;
//     aux_valid 3 cycles later with aux_data=mem[0x1ABCD].
//  3. aux_req held over 10 disp_req cycles (STARVE_MAX=8) -> aux_starved rises on
//     the 8th wait cycle; grant on first disp_req=0 cycle; aux_starved clears.
//  4. disp_req and aux_req alternating each cycle -> no dropped or duplicated valid;
//     owners and data are matched against a reference queue.
//  5. rst pulsed 1 cycle after two accepts -> no disp_valid/aux_valid afterwards;
//     all outputs at reset values.
//  6. FB_ARB_STATS_EN with 70000 aux grants -> stat_aux_grants=16'hFFFF;
//     stat_clr -> counter reads 0 next cycle.

Source files
------------

// File: rtl/fb_arb_pkg.sv
// Shared types for the frame-buffer read arbiter: default widths, the owner tags
// carried by the read pipe, and the aux-side FSM states.
package fb_arb_pkg;

    localparam int ADDR_W_DEF = 17;
    localparam int DATA_W_DEF = 12;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_AUX  = 2'd2
    } owner_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fb_read_arbiter_if.sv
// Bundle of the display, aux and frame-buffer port-B signals around the read arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface fb_read_arbiter_if
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;

    logic              aux_req;
    logic [ADDR_W-1:0] aux_addr;
    logic              aux_gnt;
    logic [DATA_W-1:0] aux_data;
    logic              aux_valid;
    logic              aux_starved;

    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_dout;

    modport slave (
        input  disp_req, disp_addr, aux_req, aux_addr, fb_dout,
        output disp_data, disp_valid, aux_gnt, aux_data, aux_valid, aux_starved, fb_addr
    );

    modport master (
        output disp_req, disp_addr, aux_req, aux_addr, fb_dout,
        input  disp_data, disp_valid, aux_gnt, aux_data, aux_valid, aux_starved, fb_addr
    );

endinterface

// File: rtl/fb_arb_tag_pipe.sv
// Shift register of owner tags that tracks each issued read until its data returns.
// Synchronous clear drops every in-flight tag.
module fb_arb_tag_pipe
    import fb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  owner_t tag_in,
    output owner_t tag_out
);

    owner_t pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= TAG_NONE;
            end
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/fb_read_arbiter.sv
// Frame-buffer port-B read arbiter: display has absolute priority, aux gets idle cycles.
// Optional statistics counters are built when FB_ARB_STATS_EN is defined.
module fb_read_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic        pclk,
    input  logic        rst,
`ifdef FB_ARB_STATS_EN
    input  logic        stat_clr,
    output logic [15:0] stat_aux_grants,
    output logic [7:0]  stat_max_wait,
`endif
    fb_read_arbiter_if.slave bus
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    arb_state_t        state, state_next;
    logic [7:0]        wait_cnt, wait_cnt_next, wait_inc;
    logic              starved_q, starved_next;
    logic              disp_take, aux_take;
    logic [ADDR_W-1:0] fb_addr_q;
    logic [DATA_W-1:0] disp_data_q, aux_data_q;
    logic              disp_valid_q, aux_valid_q;
    owner_t            tag_in, tag_out;

    assign wait_inc = sat_inc8(wait_cnt);

    // Aux-side FSM: a blocked aux request waits in ST_WAIT until display goes idle
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        starved_next  = starved_q;
        aux_take      = 1'b0;
        disp_take     = bus.disp_req;
        case (state)
            ST_IDLE: begin
                if (bus.aux_req) begin
                    if (!bus.disp_req) begin
                        aux_take      = 1'b1;
                        starved_next  = 1'b0;
                        wait_cnt_next = 8'd0;
                    end else begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = 8'd1;
                        if (8'd1 >= STARVE_LIM) begin
                            starved_next = 1'b1;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.aux_req) begin
                    state_next    = ST_IDLE;
                    wait_cnt_next = 8'd0;
                end else if (!bus.disp_req) begin
                    aux_take      = 1'b1;
                    starved_next  = 1'b0;
                    wait_cnt_next = 8'd0;
                    state_next    = ST_IDLE;
                end else begin
                    wait_cnt_next = wait_inc;
                    if (wait_inc >= STARVE_LIM) begin
                        starved_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next    = ST_IDLE;
                wait_cnt_next = 8'd0;
            end
        endcase
    end

    assign bus.aux_gnt = aux_take && !rst;

    always_comb begin
        tag_in = TAG_NONE;
        if (disp_take) begin
            tag_in = TAG_DISP;
        end else if (aux_take) begin
            tag_in = TAG_AUX;
        end
    end

    // Address register to port B holds when nothing is accepted
    always_ff @(posedge pclk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= 8'd0;
            starved_q <= 1'b0;
            fb_addr_q <= '0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_cnt_next;
            starved_q <= starved_next;
            if (disp_take) begin
                fb_addr_q <= bus.disp_addr;
            end else if (aux_take) begin
                fb_addr_q <= bus.aux_addr;
            end
        end
    end

    fb_arb_tag_pipe #(
        .DEPTH(RD_LAT + 1)
    ) u_tag_pipe (
        .clk    (pclk),
        .rst    (rst),
        .tag_in (tag_in),
        .tag_out(tag_out)
    );

    // Returned data is steered by the tag that matured alongside it
    always_ff @(posedge pclk) begin
        if (rst) begin
            disp_data_q  <= '0;
            aux_data_q   <= '0;
            disp_valid_q <= 1'b0;
            aux_valid_q  <= 1'b0;
        end else begin
            disp_valid_q <= (tag_out == TAG_DISP);
            aux_valid_q  <= (tag_out == TAG_AUX);
            if (tag_out == TAG_DISP) begin
                disp_data_q <= bus.fb_dout;
            end
            if (tag_out == TAG_AUX) begin
                aux_data_q <= bus.fb_dout;
            end
        end
    end

    assign bus.fb_addr     = fb_addr_q;
    assign bus.disp_data   = disp_data_q;
    assign bus.disp_valid  = disp_valid_q;
    assign bus.aux_data    = aux_data_q;
    assign bus.aux_valid   = aux_valid_q;
    assign bus.aux_starved = starved_q;

`ifdef FB_ARB_STATS_EN
    logic [15:0] grants_q;
    logic [7:0]  max_wait_q;

    always_ff @(posedge pclk) begin
        if (rst || stat_clr) begin
            grants_q   <= 16'd0;
            max_wait_q <= 8'd0;
        end else if (aux_take) begin
            if (grants_q != 16'hFFFF) begin
                grants_q <= grants_q + 16'd1;
            end
            if (wait_cnt > max_wait_q) begin
                max_wait_q <= wait_cnt;
            end
        end
    end

    assign stat_aux_grants = grants_q;
    assign stat_max_wait   = max_wait_q;
`endif

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Self-checking bench for fb_read_arbiter with a queue-based reference model.
// Exercises the statistics counters as well when FB_ARB_STATS_EN is defined.
module tb_fb_read_arbiter;
    import fb_arb_pkg::*;

    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 12;
    localparam int RD_LAT     = 1;
    localparam int STARVE_MAX = 8;

    logic pclk = 1'b0;
    logic rst  = 1'b1;

    always #5 pclk = ~pclk;

    fb_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef FB_ARB_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_aux_grants;
    logic [7:0]  stat_max_wait;
`endif

    fb_read_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RD_LAT    (RD_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .pclk           (pclk),
        .rst            (rst),
`ifdef FB_ARB_STATS_EN
        .stat_clr       (stat_clr),
        .stat_aux_grants(stat_aux_grants),
        .stat_max_wait  (stat_max_wait),
`endif
        .bus            (bus)
    );

    function automatic logic [DATA_W-1:0] memf(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] h;
        h = a ^ (a >> 7) ^ 17'h0A5A5;
        return h[11:0] ^ {h[16:12], 7'b0};
    endfunction

    // Port-B memory model with RD_LAT cycles of read latency
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    always @(posedge pclk) begin
        rd_pipe[0] <= memf(bus.fb_addr);
        for (int i = 1; i < RD_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign bus.fb_dout = rd_pipe[RD_LAT-1];

    typedef struct {
        int                due;
        bit                is_aux;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    typedef struct {
        logic              gnt;
        logic              dv;
        logic              av;
        logic              starved;
        logic [DATA_W-1:0] dd;
        logic [DATA_W-1:0] ad;
        logic [ADDR_W-1:0] fb;
    } obs_t;

    typedef struct {
        bit                dr;
        logic [ADDR_W-1:0] da;
        bit                ar;
        logic [ADDR_W-1:0] aa;
        bit                eg;
        bit                edv;
        bit                eav;
    } vec_t;

    exp_t              q[$];
    int                cyc = 0;
    int                checks = 0;
    int                errors = 0;
    logic [DATA_W-1:0] m_dd, m_ad;
    logic [ADDR_W-1:0] m_fb;
    bit                m_starved;
    int                m_blocked;
    int                m_grants, m_maxw;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_dd      = '0;
        m_ad      = '0;
        m_fb      = '0;
        m_starved = 1'b0;
        m_blocked = 0;
    endtask

    task automatic run_cycle(input bit dr, input logic [ADDR_W-1:0] da, input bit ar,
                             input logic [ADDR_W-1:0] aa, input bit rs, output obs_t o);
        bit e_gnt, e_dv, e_av, clr;
        bus.disp_req  = dr;
        bus.disp_addr = da;
        bus.aux_req   = ar;
        bus.aux_addr  = aa;
        rst           = rs;
        clr           = 1'b0;
`ifdef FB_ARB_STATS_EN
        clr = stat_clr;
`endif
        @(negedge pclk);
        o.gnt     = bus.aux_gnt;
        o.dv      = bus.disp_valid;
        o.av      = bus.aux_valid;
        o.starved = bus.aux_starved;
        o.dd      = bus.disp_data;
        o.ad      = bus.aux_data;
        o.fb      = bus.fb_addr;

        e_gnt = ar && !dr && !rs;
        e_dv  = 1'b0;
        e_av  = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            if (q[0].is_aux) begin
                e_av = 1'b1;
                m_ad = memf(q[0].addr);
            end else begin
                e_dv = 1'b1;
                m_dd = memf(q[0].addr);
            end
            void'(q.pop_front());
        end
        check("aux_gnt", o.gnt, e_gnt);
        check("disp_valid", o.dv, e_dv);
        check("aux_valid", o.av, e_av);
        check("disp_data", o.dd, m_dd);
        check("aux_data", o.ad, m_ad);
        check("aux_starved", o.starved, m_starved);
        check("fb_addr", o.fb, m_fb);
`ifdef FB_ARB_STATS_EN
        check("stat_aux_grants", stat_aux_grants, m_grants);
        check("stat_max_wait", stat_max_wait, m_maxw);
`endif

        if (rs || clr) begin
            m_grants = 0;
            m_maxw   = 0;
        end else if (e_gnt) begin
            if (m_grants < 65535) m_grants++;
            if (m_blocked > m_maxw) m_maxw = m_blocked;
        end

        if (rs) begin
            model_clear();
        end else begin
            if (dr) begin
                q.push_back('{due: cyc + 2 + RD_LAT, is_aux: 1'b0, addr: da});
                m_fb = da;
            end else if (e_gnt) begin
                q.push_back('{due: cyc + 2 + RD_LAT, is_aux: 1'b1, addr: aa});
                m_fb = aa;
            end
            if (e_gnt) begin
                m_blocked = 0;
                m_starved = 1'b0;
            end else if (ar && dr) begin
                if (m_blocked < 255) m_blocked++;
                if (m_blocked >= STARVE_MAX) m_starved = 1'b1;
            end else begin
                m_blocked = 0;
            end
        end
        @(posedge pclk);
        #1;
        cyc++;
    endtask

    vec_t              tbl[12];
    obs_t              o;
    bit                pend;
    logic [ADDR_W-1:0] paddr;
    int                nd, na;

    initial begin
        bus.disp_req  = 1'b0;
        bus.disp_addr = '0;
        bus.aux_req   = 1'b0;
        bus.aux_addr  = '0;
        m_grants      = 0;
        m_maxw        = 0;
        model_clear();
        repeat (2) @(posedge pclk);
        #1;
        repeat (2) run_cycle(0, 0, 0, 0, 1, o);

        check("reset disp_valid", o.dv, 0);
        check("reset fb_addr", o.fb, 0);

        // Directed table: single aux read, priority, back-to-back aux grants
        tbl[0]  = '{0, 17'h00000, 1, 17'h1ABCD, 1, 0, 0};
        tbl[1]  = '{0, 17'h00000, 0, 17'h00000, 0, 0, 0};
        tbl[2]  = '{0, 17'h00000, 0, 17'h00000, 0, 0, 0};
        tbl[3]  = '{0, 17'h00000, 0, 17'h00000, 0, 0, 1};
        tbl[4]  = '{1, 17'h00010, 0, 17'h00000, 0, 0, 0};
        tbl[5]  = '{1, 17'h00011, 1, 17'h00100, 0, 0, 0};
        tbl[6]  = '{0, 17'h00000, 1, 17'h00100, 1, 0, 0};
        tbl[7]  = '{0, 17'h00000, 1, 17'h00101, 1, 1, 0};
        tbl[8]  = '{0, 17'h00000, 0, 17'h00000, 0, 1, 0};
        tbl[9]  = '{0, 17'h00000, 0, 17'h00000, 0, 0, 1};
        tbl[10] = '{0, 17'h00000, 0, 17'h00000, 0, 0, 1};
        tbl[11] = '{0, 17'h00000, 0, 17'h00000, 0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            run_cycle(tbl[i].dr, tbl[i].da, tbl[i].ar, tbl[i].aa, 0, o);
            check("tbl_gnt", o.gnt, tbl[i].eg);
            check("tbl_disp_valid", o.dv, tbl[i].edv);
            check("tbl_aux_valid", o.av, tbl[i].eav);
            if (i == 3) check("tbl_aux_data_1ABCD", o.ad, memf(17'h1ABCD));
        end

        // Display streaming 320 pixels with aux blocked behind it
        for (int n = 0; n < 323; n++) begin
            run_cycle(n < 320, 17'(n), n <= 320, 17'h0BEEF, 0, o);
            if (n < 320) check("stream_no_gnt", o.gnt, 0);
            if (n == 320) check("stream_gnt_after", o.gnt, 1);
            if (n >= 3) begin
                check("stream_valid", o.dv, 1);
                check("stream_data", o.dd, memf(17'(n - 3)));
            end
        end
        repeat (2) run_cycle(0, 0, 0, 0, 0, o);

        // Starvation: aux held across 10 display cycles
        repeat (2) run_cycle(0, 0, 0, 0, 1, o);
        for (int i = 0; i < 10; i++) begin
            run_cycle(1, 17'(i + 100), 1, 17'h0F0F0, 0, o);
            if (i == 7) check("starved_before", o.starved, 0);
            if (i == 8) check("starved_raised", o.starved, 1);
        end
        run_cycle(0, 0, 1, 17'h0F0F0, 0, o);
        check("starved_grant", o.gnt, 1);
        run_cycle(0, 0, 0, 0, 0, o);
        check("starved_cleared", o.starved, 0);
        repeat (3) run_cycle(0, 0, 0, 0, 0, o);

        // Alternating requesters, aux always pending
        nd = 0;
        na = 0;
        paddr = 17'h10000;
        for (int i = 0; i < 44; i++) begin
            run_cycle((i % 2 == 0) && i < 40, 17'(i + 17'h00200), i < 40, paddr, 0, o);
            if (i < 40) check("alt_gnt", o.gnt, i % 2 == 1);
            if (o.gnt) paddr = paddr + 17'd1;
            if (o.dv) nd++;
            if (o.av) na++;
        end
        check("alt_disp_count", nd, 20);
        check("alt_aux_count", na, 20);

        // Reset one cycle after two accepts drops both reads
        run_cycle(1, 17'h00123, 0, 0, 0, o);
        run_cycle(0, 0, 1, 17'h00456, 0, o);
        run_cycle(0, 0, 0, 0, 1, o);
        for (int i = 0; i < 5; i++) begin
            run_cycle(0, 0, 0, 0, 0, o);
            check("post_rst_dv", o.dv, 0);
            check("post_rst_av", o.av, 0);
            check("post_rst_dd", o.dd, 0);
            check("post_rst_ad", o.ad, 0);
            check("post_rst_fb", o.fb, 0);
        end

        // Randomized traffic against the reference model
        pend = 1'b0;
        paddr = '0;
        for (int i = 0; i < 2500; i++) begin
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend  = 1'b1;
                paddr = 17'($urandom);
            end else if (pend && $urandom_range(0, 63) == 0) begin
                pend = 1'b0;
            end
            run_cycle($urandom_range(0, 3) != 0, 17'($urandom), pend, paddr, $urandom_range(0, 499) == 0, o);
            if (o.gnt) pend = 1'b0;
        end
        repeat (4) run_cycle(0, 0, 0, 0, 0, o);

`ifdef FB_ARB_STATS_EN
        // Saturating grant counter and clear
        for (int i = 0; i < 70000; i++) begin
            run_cycle(0, 0, 1, 17'(i), 0, o);
        end
        run_cycle(0, 0, 0, 0, 0, o);
        check("stat_saturated", stat_aux_grants, 16'hFFFF);
        stat_clr = 1'b1;
        run_cycle(0, 0, 1, 17'h00001, 0, o);
        stat_clr = 1'b0;
        run_cycle(0, 0, 0, 0, 0, o);
        check("stat_cleared", stat_aux_grants, 0);
        check("stat_max_cleared", stat_max_wait, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
